// File: rtl/mcyc_div_radix_pkg.sv
// Shared mdiv definitions: FSM states, op-field positions and
// width-generic special-case result constants.
package mcyc_div_radix_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam int OP_SIGNED = 0;
  localparam int OP_REM    = 1;
  localparam int OP_WORD   = 2;
  localparam int OP_W      = 3;

  localparam int MAXW = 64;

  function automatic logic [MAXW-1:0] ones_val(int w);
    logic [MAXW-1:0] v;
    v = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [MAXW-1:0] min_val(int w);
    logic [MAXW-1:0] v;
    v = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (i == w - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/mcyc_div_radix_step.sv
// One restoring division step: shift in a dividend bit,
// subtract the divisor when it fits, emit the quotient bit.
module div_radix2_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN:0]   rem_in,
  input  logic            bit_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic            q
);

  logic [XLEN:0] sh;
  logic          ge;

  assign sh = {rem_in[XLEN-1:0], bit_in};
  // A bit carried out of the shift always means the divisor fits.
  assign ge = rem_in[XLEN] | (sh >= {1'b0, divisor});
  assign q = ge;
  assign rem_out = ge ? sh - {1'b0, divisor} : sh;

endmodule

// File: rtl/mcyc_div_radix.sv
// Iterative RISC-V M-extension divider retiring 2^RADIX_LOG2
// quotient bits per cycle, valid/ready on request and response.
module mcyc_div_radix
  import mcyc_div_radix_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int RADIX_LOG2 = 1,
  parameter int HAS_W      = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_signed,
  input  logic            req_rem,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_dividend,
  input  logic [XLEN-1:0] req_divisor,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data
);

  localparam int R  = 1 << RADIX_LOG2;
  localparam int NF = XLEN / R;
  localparam int NW = 32 / R;
  localparam int CW = $clog2(NF) + 1;
  localparam bit WEN = (HAS_W != 0) && (XLEN > 32);

  function automatic logic [XLEN-1:0] sx(logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = v;
    for (int i = 32; i < XLEN; i++) r[i] = v[31];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zx(logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = v;
    for (int i = 32; i < XLEN; i++) r[i] = 1'b0;
    return r;
  endfunction

  state_t          state, state_n;
  logic [CW-1:0]   cnt, n_last;
  logic [OP_W-1:0] op_q;
  logic            neg_q, neg_r;
  logic [XLEN:0]   rem_q, rem_n;
  logic [XLEN-1:0] dvd_q, dvd_n, dvs_q;

  logic            word_in, accept, dz, ovf, a_neg, b_neg;
  logic [XLEN-1:0] a_x, b_x, a_abs, b_abs;
  logic [XLEN-1:0] ones, min_f, min_w, spec_res, spec_data;
  logic [XLEN-1:0] qs, rs, res, fix_data;

  assign ones  = XLEN'(ones_val(XLEN));
  assign min_f = XLEN'(min_val(XLEN));
  assign min_w = sx(XLEN'(min_val(32)));

  assign word_in = WEN ? req_word : 1'b0;
  assign a_x = word_in ? (req_signed ? sx(req_dividend) : zx(req_dividend))
                       : req_dividend;
  assign b_x = word_in ? (req_signed ? sx(req_divisor) : zx(req_divisor))
                       : req_divisor;
  assign a_neg = req_signed & a_x[XLEN-1];
  assign b_neg = req_signed & b_x[XLEN-1];
  assign a_abs = a_neg ? -a_x : a_x;
  assign b_abs = b_neg ? -b_x : b_x;

  assign dz  = (b_x == '0);
  assign ovf = req_signed && (a_x == (word_in ? min_w : min_f)) && (b_x == ones);
  assign spec_res = dz ? (req_rem ? a_x : ones) : (req_rem ? '0 : a_x);
  assign spec_data = word_in ? sx(spec_res) : spec_res;

  assign req_ready = (state == IDLE);
  assign accept = req_valid && req_ready && !flush;
  assign n_last = op_q[OP_WORD] ? CW'(NW - 1) : CW'(NF - 1);

  // Chained restoring steps, MSB-first through the shifted dividend.
  logic [XLEN:0] chain [R+1];
  logic [R-1:0]  qv;

  assign chain[0] = rem_q;

  for (genvar k = 0; k < R; k++) begin : g_step
    div_radix2_step #(.XLEN(XLEN)) u_step (
      .rem_in  (chain[k]),
      .bit_in  (dvd_q[XLEN-1-k]),
      .divisor (dvs_q),
      .rem_out (chain[k+1]),
      .q       (qv[R-1-k])
    );
  end

  assign rem_n = chain[R];
  assign dvd_n = {dvd_q[XLEN-R-1:0], qv};

  assign qs = neg_q ? -dvd_q : dvd_q;
  assign rs = neg_r ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  assign res = op_q[OP_REM] ? rs : qs;
  assign fix_data = op_q[OP_WORD] ? sx(res) : res;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = (dz || ovf) ? DONE : CALC;
      CALC: if (cnt == n_last) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      cnt        <= (state == CALC) ? cnt + CW'(1) : '0;
      resp_valid <= (state_n == DONE);
      if (accept) begin
        op_q  <= {word_in, req_rem, req_signed};
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        dvs_q <= b_abs;
        rem_q <= '0;
        // Word ops left-align so the loop starts at bit 31.
        dvd_q <= word_in ? (a_abs << (XLEN - 32)) : a_abs;
        if (dz || ovf) resp_data <= spec_data;
      end
      if (state == CALC) begin
        rem_q <= rem_n;
        dvd_q <= dvd_n;
      end
      if (state == FIX) resp_data <= fix_data;
    end
  end

endmodule
